// File: rtl/multi_pkg.sv
// Shared constants for the multi_5x5 array multiplier and its benches.
package multi_pkg;

  localparam int unsigned WIDTH_DEF  = 5;
  localparam int unsigned PROD_W_DEF = 2 * WIDTH_DEF;

  function automatic int unsigned max_product(input int unsigned w);
    return ((2 ** w) - 1) * ((2 ** w) - 1);
  endfunction

  localparam int unsigned MAX_PROD_DEF = max_product(WIDTH_DEF);

endpackage

// File: rtl/multi_fa.sv
// One-bit full adder: the cell from which the ripple rows are built.
module multi_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multi_5x5.sv
// Unsigned array multiplier: AND partial products summed by ripple-carry rows,
// product registered once (one cycle latency, one product per cycle).
module multi_5x5
  import multi_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   res,
  output logic                 res_valid
);

  logic [2*WIDTH-1:0] res_d;
  logic [2*WIDTH-1:0] res_q;
  logic               valid_q;

  // Row s adds partial product s to the previous row's running sum shifted
  // down one place; the bit that drops out is product bit s.
  for (genvar s = 0; s < WIDTH; s++) begin : g_row
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign pp = a & {WIDTH{b[s]}};

    if (s == 0) begin : g_first
      assign sum  = pp;
      assign cout = 1'b0;
    end else begin : g_add
      logic [WIDTH-1:0] x;
      assign x = {g_row[s-1].cout, g_row[s-1].sum[WIDTH-1:1]};

      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        logic ci;
        logic co;
        if (j == 0) begin : g_c0
          assign ci = 1'b0;
        end else begin : g_cn
          assign ci = g_bit[j-1].co;
        end
        multi_fa u_fa (
          .a   (x[j]),
          .b   (pp[j]),
          .cin (ci),
          .sum (sum[j]),
          .cout(co)
        );
      end

      assign cout = g_bit[WIDTH-1].co;
    end

    assign res_d[s] = sum[0];
  end

  assign res_d[2*WIDTH-1:WIDTH] = {g_row[WIDTH-1].cout, g_row[WIDTH-1].sum[WIDTH-1:1]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= 1'b1;
    end
  end

  assign res       = res_q;
  assign res_valid = valid_q;

endmodule

// File: tb/tb_multi_5x5.sv
// Scoreboard bench for multi_5x5: stimulus pushes expected products, a monitor
// pops and compares one cycle after each issued operand pair.
module tb_multi_5x5;
  import multi_pkg::*;

  localparam int unsigned W = WIDTH_DEF;

  logic             clock;
  logic             resetn;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   res;
  logic             res_valid;

  int unsigned n_total;
  int unsigned n_pass;

  logic [2*W-1:0] exp_q[$];
  string          tag_q[$];

  multi_5x5 #(.WIDTH(W)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .a        (a),
    .b        (b),
    .res      (res),
    .res_valid(res_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    n_total++;
    if (!$isunknown(got) && got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Drive operands away from the sampling edge and record what the next edge must produce.
  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] want, input string name);
    @(negedge clock);
    a = x;
    b = y;
    exp_q.push_back(want);
    tag_q.push_back(name);
  endtask

  // Monitor: one issued pair -> one result on the following edge.
  initial begin
    logic [2*W-1:0] want;
    string          name;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        name = tag_q.pop_front();
        check({name, "_valid"}, {{(2*W-1){1'b0}}, res_valid}, 1);
        check(name, res, want);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    resetn  = 1'b0;
    a       = 5'd31;
    b       = 5'd31;

    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("rst_res", res, 0);
      check("rst_valid", {{(2*W-1){1'b0}}, res_valid}, 0);
    end

    @(negedge clock);
    resetn = 1'b1;
    a = 5'd20;
    b = 5'd20;
    exp_q.push_back(10'd400);
    tag_q.push_back("release_20x20");

    apply(5'd20, 5'd20, 10'd400, "p20x20");
    apply(5'd31, 5'd31, 10'd961, "p31x31");
    apply(5'd1,  5'd0,  10'd0,   "p1x0");
    apply(5'd0,  5'd0,  10'd0,   "p0x0");
    apply(5'd0,  5'd1,  10'd0,   "p0x1");
    apply(5'd1,  5'd17, 10'd17,  "p1x17");
    apply(5'd17, 5'd1,  10'd17,  "p17x1");
    apply(5'd16, 5'd2,  10'd32,  "p16x2");
    apply(5'd2,  5'd16, 10'd32,  "p2x16");
    apply(5'd3,  5'd5,  10'd15,  "b2b_3x5");
    apply(5'd7,  5'd9,  10'd63,  "b2b_7x9");
    apply(5'd31, 5'd30, 10'd930, "b2b_31x30");

    // Operand wiggle between edges must not disturb the registered result.
    apply(5'd31, 5'd31, 10'd961, "pre_rst_31x31");
    @(posedge clock);
    #2;
    a = 5'd0;
    b = 5'd3;
    #1;
    check("hold_between_edges", res, 10'd961);

    // Asynchronous reset mid-cycle clears res without an edge.
    resetn = 1'b0;
    #1;
    check("async_rst_res", res, 0);
    check("async_rst_valid", {{(2*W-1){1'b0}}, res_valid}, 0);

    @(negedge clock);
    resetn = 1'b1;
    a = 5'd6;
    b = 5'd7;
    exp_q.push_back(10'd42);
    tag_q.push_back("post_rst_6x7");

    for (int unsigned i = 0; i < 32; i++) begin
      for (int unsigned j = 0; j < 32; j++) begin
        apply(W'(i), W'(j), (2*W)'(i * j), "sweep");
      end
    end

    @(posedge clock);
    #3;
    check("queue_drained", (2*W)'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_5x5.md
Name: multi_5x5

Overview:
- Unsigned integer multiplier: WIDTH-bit operands a and b, 2*WIDTH-bit product res.
- Product is built from an explicit AND partial-product array summed by ripple-carry adder rows. No behavioural "*" in the datapath.
- Result is registered once, giving one clock of latency.
- Used as a small arithmetic leaf in the datapath. Default WIDTH is 5, so the product is 10 bits.

Parameters:
- WIDTH, 5, operand width in bits; product width is 2*WIDTH. Must be >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- res  output  2*WIDTH  registered unsigned product a*b.
- res_valid  output  1  high when res holds a product of sampled operands.

Behaviour:
- Reset:
  - While resetn=0, res=0 and res_valid=0, regardless of clock.
  - Assertion takes effect immediately (asynchronous).
  - Deassertion is sampled on the next rising clock edge.
- Operation:
  - On every rising edge with resetn=1, res <= a*b for the a and b present at that edge.
  - No enable and no handshake; a new product is accepted every cycle.
- Latency and throughput:
  - Latency is exactly 1 cycle: operands stable before edge N give the product on res after edge N.
  - Throughput is one product per cycle.
- res_valid:
  - Goes to 1 at the first rising edge after resetn deasserts.
  - Stays at 1 until the next reset.
- Arithmetic:
  - Fully unsigned.
  - Partial product row i is (a AND {WIDTH{b[i]}}), shifted left by i.
  - Rows are accumulated with WIDTH-1 ripple-carry adder stages.
  - The final carry forms the MSB of res.
  - The product never overflows 2*WIDTH bits. Maximum is (2^WIDTH-1)^2, which is 961 for WIDTH=5.
- Boundary conditions:
  - Either operand 0 gives res=0.
  - Either operand 1 gives res equal to the other operand, zero-extended.
  - Both operands all-ones gives (2^WIDTH-1)^2.
- Reset mid-stream:
  - res clears to 0 immediately and the in-flight product is discarded.
  - After release, the first rising edge loads the current a*b.
- Operand changes between edges have no effect on res; only edge-sampled values matter.
- X/Z on a or b is not defined behaviour. Requirement: after reset, res is never X when the inputs are driven with known values.

Decomposition:
- Shared package multi_pkg holds:
  - the default WIDTH constant (5);
  - the derived product width 2*WIDTH;
  - the localparam for the maximum product, used by benches.
- One sub-module: multi_fa, a 1-bit full adder (a, b, cin -> sum, cout).
  - Instantiated through generate loops to form the ripple rows.
  - The partial-product AND array and the output register live in multi_5x5.

Test Plan:
- Reset: hold resetn=0 with a=31, b=31 toggling clock -> res=0, res_valid=0. Release, apply 20x20 -> next edge res=400, res_valid=1.
- Directed products, one per cycle, each checked one cycle later:
  - 20x20 -> 400
  - 31x31 -> 961
  - 1x0 -> 0
  - 0x0 -> 0
  - 0x1 -> 0
- Identity and shifts:
  - 1x17 -> 17
  - 17x1 -> 17
  - 16x2 -> 32
  - 2x16 -> 32
- Back-to-back throughput: change the operands every cycle through 3x5, 7x9, 31x30 -> res sequence 15, 63, 930 with exactly 1-cycle lag and no bubbles.
- Asynchronous reset mid-stream: while res=961, pull resetn low between edges -> res=0 immediately, without waiting for a clock edge. Release with 6x7 applied -> res=42 after the next edge.
- Exhaustive sweep over all 1024 (a, b) pairs for WIDTH=5 -> res equals the golden unsigned product every cycle, with no X on res after reset.
